// File: rtl/tlu_pkg.sv
// Shared TLU types and helpers: trigger number / tagged word layout and counter arithmetic.
package tlu_pkg;

    localparam int unsigned TLU_DATA_WIDTH  = 31;
    localparam int unsigned TLU_WORD_WIDTH  = 32;
    localparam logic        TLU_WORD_MARKER = 1'b1;
    localparam int unsigned TLU_CNT_WIDTH   = 8;

    typedef logic [TLU_DATA_WIDTH-1:0] trigger_num_t;
    typedef logic [TLU_CNT_WIDTH-1:0]  tlu_cnt_t;

    // Bit 31 tags the word as a trigger word for the readout.
    typedef struct packed {
        logic         marker;
        trigger_num_t number;
    } tlu_word_t;

    // Expected successor of a trigger number; wraps 0x7FFFFFFF -> 0.
    function automatic trigger_num_t next_trigger_number(input trigger_num_t x);
        return x + TLU_DATA_WIDTH'(1);
    endfunction

    function automatic tlu_cnt_t sat_inc(input tlu_cnt_t v);
        return (v == {TLU_CNT_WIDTH{1'b1}}) ? v : v + TLU_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/tlu_word_fifo.sv
// Generic synchronous first-word-fall-through FIFO with a registered head word and flags.
module tlu_word_fifo #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic                  push_ok_c,
    output logic [WIDTH-1:0]      data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2:0]   count_nxt_c
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr_nxt_c;
    logic [WIDTH-1:0]      head_nxt_c;
    logic                  pop_ok_c;

    // A full FIFO still accepts a push when the same edge pops a word.
    always_comb begin
        pop_ok_c     = pop && !empty;
        push_ok_c    = push && (!full || pop_ok_c);
        rd_ptr_nxt_c = pop_ok_c ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
        count_nxt_c  = count;
        if (push_ok_c && !pop_ok_c) begin
            count_nxt_c = count + CW'(1);
        end else if (!push_ok_c && pop_ok_c) begin
            count_nxt_c = count - CW'(1);
        end
        // The head after this edge is the incoming word only when it lands on the new read slot.
        head_nxt_c = (push_ok_c && (rd_ptr_nxt_c == wr_ptr)) ? push_data : mem[rd_ptr_nxt_c];
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            data   <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            data   <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            rd_ptr <= rd_ptr_nxt_c;
            count  <= count_nxt_c;
            empty  <= (count_nxt_c == '0);
            full   <= (count_nxt_c == CW'(DEPTH));
            // Hold the last head when the FIFO drains so the readout sees a stable value.
            if (count_nxt_c != '0) begin
                data <= head_nxt_c;
            end
        end
    end

endmodule

// File: rtl/tlu_trigger_word_buffer.sv
// Buffers TLU trigger numbers as tagged words, acknowledges every store request,
// and tracks overflow losses and trigger-number continuity.
module tlu_trigger_word_buffer
    import tlu_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2          = 4,
    parameter int unsigned NEAR_FULL_THRESHOLD = 12
) (
    input  logic                      BUS_CLK,
    input  logic                      BUS_RST_N,
    input  logic                      CLEAR,
    input  logic                      CHECK_ENABLE,
    input  logic [TLU_DATA_WIDTH-1:0] TLU_DATA,
    input  logic                      TLU_DATA_SAVE_FLAG,
    output logic                      TLU_DATA_SAVED_FLAG,
    input  logic                      FIFO_READ,
    output logic [TLU_WORD_WIDTH-1:0] FIFO_DATA,
    output logic                      FIFO_EMPTY,
    output logic                      FIFO_FULL,
    output logic                      FIFO_NEAR_FULL,
    output logic [DEPTH_LOG2:0]       FIFO_COUNT,
    output logic [TLU_CNT_WIDTH-1:0]  LOST_COUNT,
    output logic [TLU_CNT_WIDTH-1:0]  SKIP_COUNT,
    output logic [TLU_DATA_WIDTH-1:0] LAST_TRIGGER_NUMBER
);

    localparam int unsigned CW = DEPTH_LOG2 + 1;

    tlu_word_t         word_c;
    logic              push_req_c;
    logic              push_ok_c;
    logic              lost_c;
    logic              skip_c;
    logic              first_word;
    logic [CW-1:0]     count_nxt_c;

    always_comb begin
        word_c     = '{marker: TLU_WORD_MARKER, number: TLU_DATA};
        push_req_c = TLU_DATA_SAVE_FLAG && !CLEAR;
        lost_c     = push_req_c && !push_ok_c;
        skip_c     = push_ok_c && CHECK_ENABLE && !first_word &&
                     (TLU_DATA != next_trigger_number(LAST_TRIGGER_NUMBER));
    end

    tlu_word_fifo #(
        .WIDTH      (TLU_WORD_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk         (BUS_CLK),
        .rst_n       (BUS_RST_N),
        .clear       (CLEAR),
        .push        (push_req_c),
        .push_data   (word_c),
        .pop         (FIFO_READ),
        .push_ok_c   (push_ok_c),
        .data        (FIFO_DATA),
        .empty       (FIFO_EMPTY),
        .full        (FIFO_FULL),
        .count       (FIFO_COUNT),
        .count_nxt_c (count_nxt_c)
    );

    // The acknowledge follows every request, even one discarded by CLEAR or overflow.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            TLU_DATA_SAVED_FLAG <= 1'b0;
        end else begin
            TLU_DATA_SAVED_FLAG <= TLU_DATA_SAVE_FLAG;
        end
    end

    // History only follows accepted words; dropped words leave it untouched.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            FIFO_NEAR_FULL      <= 1'b0;
            LOST_COUNT          <= '0;
            SKIP_COUNT          <= '0;
            LAST_TRIGGER_NUMBER <= '0;
            first_word          <= 1'b1;
        end else if (CLEAR) begin
            FIFO_NEAR_FULL      <= 1'b0;
            LOST_COUNT          <= '0;
            SKIP_COUNT          <= '0;
            LAST_TRIGGER_NUMBER <= '0;
            first_word          <= 1'b1;
        end else begin
            FIFO_NEAR_FULL <= (count_nxt_c >= CW'(NEAR_FULL_THRESHOLD));
            if (lost_c) begin
                LOST_COUNT <= sat_inc(LOST_COUNT);
            end
            if (skip_c) begin
                SKIP_COUNT <= sat_inc(SKIP_COUNT);
            end
            if (push_ok_c) begin
                LAST_TRIGGER_NUMBER <= TLU_DATA;
                first_word          <= 1'b0;
            end
        end
    end

endmodule
